// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            i_valid_EX;
  logic [2:0]      i_funct_3;
  logic [XLEN-1:0] i_rs1;
  logic [XLEN-1:0] i_rs2;
  logic            i_flush;
  logic            o_busy;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid_EX, i_funct_3, i_rs1, i_rs2, i_flush,
    input  o_busy, o_valid, o_result
  );

  modport slave (
    input  i_valid_EX, i_funct_3, i_rs1, i_rs2, i_flush,
    output o_busy, o_valid, o_result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M sequencer: radix-2 shift-add multiply and restoring divide
// on one 2*XLEN working register and one XLEN-wide adder.
//
//   state | meaning
//   IDLE  | waiting for an M-op; divide special cases resolved here
//   CALC  | XLEN iterations, one quotient/multiplier bit per cycle
//   FIX   | sign fix-up and result select
//   DONE  | o_valid pulse, pipeline released
module muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  muldiv_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic                r_sa;
  logic                r_sb;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_work;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_a_abs;
  logic [XLEN-1:0]     w_b_abs;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;

  logic                w_is_div;
  logic [XLEN:0]       w_add_a;
  logic [XLEN:0]       w_add_b;
  logic [XLEN+1:0]     w_sum;
  logic [2*XLEN-1:0]   w_work_next;

  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fix_res;

  // Operand prep at accept
  assign w_accept   = (r_state == S_IDLE) & bus.i_valid_EX & ~bus.i_flush;
  assign w_a_signed = bus.i_funct_3[2] ? ~bus.i_funct_3[0] : (bus.i_funct_3[1:0] != 2'b11);
  assign w_b_signed = bus.i_funct_3[2] ? ~bus.i_funct_3[0] : ~bus.i_funct_3[1];
  assign w_a_neg    = w_a_signed & bus.i_rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & bus.i_rs2[XLEN-1];
  assign w_a_abs    = w_a_neg ? -bus.i_rs1 : bus.i_rs1;
  assign w_b_abs    = w_b_neg ? -bus.i_rs2 : bus.i_rs2;

  assign w_div_zero = bus.i_funct_3[2] & (bus.i_rs2 == '0);
  assign w_ovf      = bus.i_funct_3[2] & ~bus.i_funct_3[0]
                    & (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.i_rs2 == '1);
  assign w_special  = w_div_zero | w_ovf;
  // Overflow DIV returns the dividend itself (the most negative value)
  assign w_special_res = w_div_zero ? (bus.i_funct_3[1] ? bus.i_rs1 : '1)
                                    : (bus.i_funct_3[1] ? '0 : bus.i_rs1);

  // Shared adder: multiply adds the multiplicand, divide trial-subtracts the divisor
  assign w_is_div = r_op[2];
  assign w_add_a  = w_is_div ? r_work[2*XLEN-1:XLEN-1] : {1'b0, r_work[2*XLEN-1:XLEN]};
  assign w_add_b  = w_is_div ? ~{1'b0, r_b} : {1'b0, r_b};
  assign w_sum    = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(XLEN+1){1'b0}}, w_is_div};

  always_comb begin
    w_work_next = r_work;
    if (w_is_div) begin
      // carry out of the subtract means shifted remainder >= divisor
      if (w_sum[XLEN+1])
        w_work_next = {w_sum[XLEN-1:0], r_work[XLEN-2:0], 1'b1};
      else
        w_work_next = {r_work[2*XLEN-2:0], 1'b0};
    end else begin
      if (r_work[0])
        w_work_next = {w_sum[XLEN:0], r_work[XLEN-1:1]};
      else
        w_work_next = {1'b0, r_work[2*XLEN-1:1]};
    end
  end

  assign w_prod = (r_sa ^ r_sb) ? -r_work : r_work;
  assign w_quot = (r_sa ^ r_sb) ? -r_work[XLEN-1:0] : r_work[XLEN-1:0];
  assign w_rem  = r_sa ? -r_work[2*XLEN-1:XLEN] : r_work[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quot;
      default:                w_fix_res = w_rem;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.i_flush) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_b      <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op   <= bus.i_funct_3;
            r_sa   <= w_a_neg;
            r_sb   <= w_b_neg;
            r_b    <= w_b_abs;
            r_work <= {{XLEN{1'b0}}, w_a_abs};
            r_cnt  <= '0;
            if (w_special) r_result <= w_special_res;
          end
        end
        S_CALC: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          if (!bus.i_flush) r_result <= w_fix_res;
        end
        default: ;
      endcase
    end
  end

  // Flush and reset both drop the stall and the result strobe immediately
  assign bus.o_busy   = ~i_rst & ~bus.i_flush
                      & (w_accept | (r_state == S_CALC) | (r_state == S_FIX));
  assign bus.o_valid  = ~i_rst & ~bus.i_flush & (r_state == S_DONE);
  assign bus.o_result = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, randomized ops
// against an arithmetic reference, and flush/reset/back-to-back sequences.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(32)) bus ();

  muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  logic [31:0] corners[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  task automatic drive_idle();
    bus.i_valid_EX = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_funct_3  = 3'($urandom);
    bus.i_rs1      = $urandom;
    bus.i_rs2      = $urandom;
  endtask

  task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.i_valid_EX = 1'b1;
    bus.i_flush    = 1'b0;
    bus.i_funct_3  = f;
    bus.i_rs1      = a;
    bus.i_rs2      = b;
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int busy_n;
    int got_lat;
    logic [31:0] res;
    busy_n  = 0;
    got_lat = -1;
    @(posedge clk); #1;
    present(f, a, b);
    @(negedge clk);
    busy_n += int'(bus.o_busy);
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      if (bus.o_valid) begin
        got_lat = n;
        break;
      end
      busy_n += int'(bus.o_busy);
    end
    res = bus.o_result;
    check({tag, " latency"}, 64'(got_lat), 64'(lat));
    check({tag, " result"}, 64'(res), 64'(exp));
    check({tag, " busy cycles"}, 64'(busy_n), 64'(lat));
    check({tag, " busy in done"}, 64'(bus.o_busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " pulse width"}, 64'(bus.o_valid), 64'd0);
    check({tag, " result hold"}, 64'(bus.o_result), 64'(res));
  endtask

  initial begin
    int vcount;
    int pulses;
    int q[$];
    logic [31:0] rq[$];
    logic [2:0]  f;
    logic [31:0] a, b;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
    vecs[5]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
    vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[8]  = '{3'd4, 32'h1234_5678,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'h1234_5678,  32'd0,         32'h1234_5678, 1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
    vecs[12] = '{3'd5, 32'hDEAD_BEEF,  32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd7, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1};
    vecs[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         34};
    vecs[15] = '{3'd0, 32'h0001_0003,  32'h0002_0005, 32'h000B_000F, 34};
    vcount = 16;

    corners[0] = 32'h0;
    corners[1] = 32'h1;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'h2;

    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 64'(bus.o_busy), 64'd0);
    check("reset valid", 64'(bus.o_valid), 64'd0);
    check("reset result", 64'(bus.o_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vcount; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      run_op(f, a, b, ref_op(f, a, b), ref_lat(f, a, b), $sformatf("rand%0d f%0d", i, f));
    end

    // Flush mid-CALC, then a fresh MUL one cycle later
    pulses = 0;
    @(posedge clk); #1;
    present(3'd0, 32'd7, 32'd3);
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk); #1;
      drive_idle();
      if (n == 10) bus.i_flush = 1'b1;
      if (n == 11) present(3'd0, 32'd3, 32'd5);
      @(negedge clk);
      if (n == 9)  check("flush busy before", 64'(bus.o_busy), 64'd1);
      if (n == 10) check("flush busy drop", 64'(bus.o_busy), 64'd0);
      if (n == 11) check("flush new accept busy", 64'(bus.o_busy), 64'd1);
      if (n < 45 && bus.o_valid) pulses++;
      if (n == 45) begin
        check("flush new valid", 64'(bus.o_valid), 64'd1);
        check("flush new result", 64'(bus.o_result), 64'd15);
      end
    end
    check("flush killed pulses", 64'(pulses), 64'd0);

    // Flush coincident with DONE
    @(posedge clk); #1;
    present(3'd0, 32'd6, 32'd7);
    pulses = 0;
    for (int n = 1; n <= 36; n++) begin
      @(posedge clk); #1;
      drive_idle();
      if (n == 34) bus.i_flush = 1'b1;
      @(negedge clk);
      if (bus.o_valid) pulses++;
      if (n == 34) check("done flush busy", 64'(bus.o_busy), 64'd0);
    end
    check("done flush pulses", 64'(pulses), 64'd0);

    // Back-to-back DIVU; an op held in DONE must be ignored
    q.delete();
    rq.delete();
    @(posedge clk); #1;
    present(3'd5, 32'd100, 32'd7);
    for (int n = 1; n <= 72; n++) begin
      @(posedge clk); #1;
      drive_idle();
      if (n == 34) present(3'd0, 32'd9, 32'd9);
      if (n == 35) present(3'd5, 32'd1000, 32'd9);
      @(negedge clk);
      if (n == 34) check("b2b busy in done", 64'(bus.o_busy), 64'd0);
      if (bus.o_valid) begin
        q.push_back(n);
        rq.push_back(bus.o_result);
      end
    end
    check("b2b pulse count", 64'(q.size()), 64'd2);
    check("b2b first at", 64'((q.size() > 0) ? q[0] : -1), 64'd34);
    check("b2b first result", 64'((rq.size() > 0) ? rq[0] : 32'hX), 64'd14);
    check("b2b second at", 64'((q.size() > 1) ? q[1] : -1), 64'd69);
    check("b2b second result", 64'((rq.size() > 1) ? rq[1] : 32'hX), 64'd111);

    // Reset mid-operation clears everything
    @(posedge clk); #1;
    present(3'd5, 32'd100, 32'd7);
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      drive_idle();
      rst = (n == 20);
      @(negedge clk);
      if (n == 21) begin
        check("rst busy", 64'(bus.o_busy), 64'd0);
        check("rst valid", 64'(bus.o_valid), 64'd0);
        check("rst result", 64'(bus.o_result), 64'd0);
      end
      if (bus.o_valid) pulses++;
    end
    check("rst killed pulses", 64'(pulses), 64'd0);

    run_op(3'd0, 32'd3, 32'd5, 32'd15, 34, "post reset mul");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer for the Osiris I EX stage.
- Sits beside the ALU. It accepts an M-extension op when the decoder flags one, stalls the pipeline while it iterates, and returns a single result beat.
- Radix-2 shift-add multiplier and restoring divider share one 64-bit working register and one 32-bit adder.
- An FSM controls operand setup, iteration, sign fix-up and result handoff.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset
- i_valid_EX  input  1  M-op present in EX
- i_funct_3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_rs1  input  XLEN  operand A
- i_rs2  input  XLEN  operand B
- i_flush  input  1  kill in-flight op (branch/trap)
- o_busy  output  1  stall request to hazard unit
- o_valid  output  1  result valid, one-cycle pulse
- o_result  output  XLEN  result

Interface: one clock (i_clk); reset (i_rst) is synchronous and active-high.

Behaviour:
- Reset values:
  - state=IDLE, counter=0, o_valid=0, o_result=0.
  - o_busy=0 (combinational; 0 whenever IDLE and i_valid_EX=0).
- States are IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when i_valid_EX=1 and i_flush=0; latch funct_3, operands and signs.
  - If divide-by-zero or signed overflow applies, go to DONE. Otherwise go to CALC with counter=0.
- Operand prep:
  - A is signed for MUL, MULH, MULHSU, DIV, REM. B is signed for MUL, MULH, DIV, REM.
  - Signed negative operands are converted to their absolute value. The iteration is always unsigned.
- CALC: exactly XLEN cycles, one bit per cycle, counter increments each cycle.
  - Multiply: if multiplier LSB=1, add multiplicand to upper half; then shift the 64-bit product right by 1 (carry kept).
  - Divide: shift {rem,quot} left by 1; trial-subtract divisor from rem; if non-negative, keep the difference and set quot LSB=1.
  - When counter=XLEN-1, go to FIX.
- FIX: one cycle.
  - Multiply: negate the 64-bit product if sign(A)^sign(B), considering only signed operands.
  - Divide: negate quotient if sign(A)^sign(B); negate remainder if sign(A).
  - Select the result: MUL gives the low word; MULH/MULHSU/MULHU give the high word; DIV/DIVU give the quotient; REM/REMU give the remainder.
  - Go to DONE.
- DONE: o_valid=1 for one cycle and o_result is registered; then go to IDLE. i_valid_EX is ignored in DONE.
- Latency (accept at cycle T):
  - Normal op: o_valid at T+XLEN+2 (T+34).
  - Special-case op: o_valid at T+1.
- o_busy is high in each of these conditions:
  - (IDLE & i_valid_EX & ~i_flush)
  - CALC
  - FIX
- o_busy is low in DONE so the pipeline advances with the result.
- Special cases resolved in IDLE, with no iteration:
  - DIV/DIVU with B=0: result 0xFFFFFFFF.
  - REM/REMU with B=0: result = A.
  - DIV with A=0x80000000, B=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- o_result holds its last value when o_valid=0.
- i_flush in any state:
  - Next state is IDLE and no o_valid is produced for the killed op.
  - o_busy drops in the same cycle.
  - A flush coincident with the DONE cycle still suppresses o_valid.
- i_rst mid-operation: same as flush, and o_result clears to 0.
- Operands are sampled only at accept. Changes on i_rs1/i_rs2 during CALC have no effect.

Test Plan:
- MUL: A=7, B=0xFFFFFFFD at T -> o_busy high T..T+33, o_valid at T+34, o_result=0xFFFFFFEB.
- MULH: A=B=0x80000000 -> 0x40000000. MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIVU 100/7 -> 14, REMU 100/7 -> 2. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD, REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. All results at T+34.
- Special cases: DIV 0x12345678/0 -> 0xFFFFFFFF at T+1. REM 0x12345678/0 -> 0x12345678. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0. o_busy high only in cycle T.
- Flush: i_flush at T+10 -> o_busy low at T+10, no o_valid through T+40. A new MUL 3*5 accepted at T+11 -> o_result=15 at T+45.
- Reset/back-to-back: i_rst at T+20 -> all outputs 0 at T+21. Two consecutive DIVU ops (second presented at T+35) -> valid pulses at T+34 and T+69, with no dropped or duplicated pulse.
